deserializer_fsm: RTL and testbench
===================================

Name: deserializer_fsm

Overview:
Serial-to-parallel stage of the FIR filter datapath. Sits directly downstream of the serializer: consumes its LSB-first bit stream under a valid/ready handshake and reassembles LENGTH-bit words. The block is double-buffered (shift register plus output register), so it can collect the next word while the previous one waits for the consumer. It applies backpressure only when both buffers are occupied.

Parameters:
LENGTH, 24, bits per word; must be >= 2.
LENGTH_BITS, $clog2(LENGTH+1), localparam; bit-counter width, derived and not overridable.

Ports:
i_clk  in  1  sole clock; all state updates on the rising edge.
i_rst  in  1  asynchronous, active-high reset.
i_en  in  1  clock enable; when low, all state, counters and outputs hold and no handshake completes.
i_din  in  1  serial data bit, LSB of the word first.
i_din_valid  in  1  upstream bit valid.
o_ready  out  1  bit-side ready; a bit is accepted when i_en && i_din_valid && o_ready.
ov_dout  out  LENGTH  reassembled word.
o_dout_valid  out  1  ov_dout holds an undelivered word.
i_ready  in  1  downstream ready; a word transfers when i_en && o_dout_valid && i_ready.
o_busy  out  1  high while a partial word is in the shift register (state SHIFT or FULL).

Behaviour:
- Reset, asynchronous and active-high: state=IDLE; counter=0; shift_reg=0; ov_dout=0; o_dout_valid=0; o_busy=0.
- o_ready is 0 while i_rst is high. Otherwise it is combinational from state: 1 in IDLE and SHIFT, 0 in FULL.
- Bit accept: shift_reg <= {i_din, shift_reg[LENGTH-1:1]}; counter <= counter+1. The first accepted bit ends up at ov_dout[0].
- States:
  - IDLE: counter=0. An accepted bit moves to SHIFT.
  - SHIFT: accumulates bits. On acceptance of the LENGTH-th bit (counter==LENGTH-1 at acceptance), call this "word complete":
    - If the output register is free (o_dout_valid==0) or drains this same cycle: ov_dout <= completed word; o_dout_valid <= 1; counter <= 0; go to IDLE.
    - Otherwise: hold the word in shift_reg; go to FULL.
  - FULL: o_ready=0 and no bits are accepted. When the output transfers: ov_dout <= shift_reg; o_dout_valid stays 1; counter <= 0; shift_reg <= 0; go to IDLE.
  - Unused encoding: go to IDLE.
- Output side:
  - On a transfer with no new word loading the same cycle, o_dout_valid <= 0. ov_dout keeps its last value.
  - ov_dout must not change while o_dout_valid=1 and no transfer occurs.
- Latency: last bit accepted in cycle N, so o_dout_valid=1 with the word in cycle N+1 (output free). From FULL: transfer in cycle M, so the next word is valid in M+1 with no bubble.
- Simultaneous events:
  - Transfer and word completion in the same cycle: the new word replaces the old; o_dout_valid stays 1.
  - i_din_valid held low mid-word: partial state is retained indefinitely; no timeout.
- i_en low: everything freezes, including FSM, counter, o_dout_valid and ov_dout. o_ready still reflects state, but no handshake completes.
- Reset mid-word or in FULL: the partial word and the pending output are discarded; the block returns to the reset values.
- Throughput: one bit per cycle sustained; never drops or duplicates a bit or a word.

Decomposition:
- The shared fir_filter package/header holds the state encodings, IDLE=2'b00, SHIFT=2'b01, FULL=2'b10, so the serializer and deserializer use identical values.
- No sub-module. The block is one FSM, one counter and two registers; a separate shift-register module adds nothing.

Test Plan:
- LENGTH=24; after reset, stream 24'hA5C30F LSB-first with i_din_valid=1 and i_ready=1 every cycle -> ov_dout=24'hA5C30F with o_dout_valid=1 exactly one cycle after the 24th bit, and a 1-cycle valid pulse.
- Back-to-back words 24'h000001 then 24'h800000, continuous bits, i_ready=1 -> o_ready never drops; two valid pulses exactly 24 cycles apart with the correct values.
- i_ready=0 while words 24'h123456 and 24'hABCDEF stream in -> first word held on ov_dout; FSM in FULL and o_ready=0 after bit 48. Raise i_ready one cycle -> 24'hABCDEF appears the next cycle, o_ready=1 again, and no bits are lost.
- i_din_valid toggled randomly 50% and i_en pulsed low mid-word, word 24'h5A5A5A -> correct word; no state change in any i_en=0 cycle.
- Assert i_rst asynchronously after 10 bits of a word, then send a full 24'h00FF00 -> o_dout_valid=0 and ov_dout=0 immediately after reset; the next word is assembled correctly, with no residue from the 10 bits.
- Word completes in the same cycle that a pending word transfers -> the new word is valid the next cycle; o_dout_valid never deasserts and the scoreboard sees both words in order.

Source files
------------

// File: rtl/fir_filter_pkg.sv
// Shared FIR-filter datapath definitions: serializer/deserializer state encodings
// and the default word width.
package fir_filter_pkg;

  localparam int unsigned DEFAULT_LENGTH = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    FULL  = 2'b10
  } ser_state_t;

endpackage

// File: rtl/deserializer_fsm.sv
// LSB-first serial-to-parallel stage with a shift register plus an output register,
// so the next word can be collected while the previous one waits downstream.
module deserializer_fsm
  import fir_filter_pkg::*;
#(
  parameter int unsigned LENGTH = DEFAULT_LENGTH
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_din,
  input  logic              i_din_valid,
  output logic              o_ready,
  output logic [LENGTH-1:0] ov_dout,
  output logic              o_dout_valid,
  input  logic              i_ready,
  output logic              o_busy
);

  localparam int unsigned LENGTH_BITS = $clog2(LENGTH + 1);

  ser_state_t             state;
  logic [LENGTH_BITS-1:0] counter;
  logic [LENGTH-1:0]      shift_reg;

  logic              bit_accept;
  logic              word_xfer;
  logic              last_bit;
  logic [LENGTH-1:0] shift_next;

  assign o_ready    = !i_rst && ((state == IDLE) || (state == SHIFT));
  assign bit_accept = i_en && i_din_valid && o_ready;
  assign word_xfer  = i_en && o_dout_valid && i_ready;
  assign last_bit   = (counter == LENGTH_BITS'(LENGTH - 1));
  assign shift_next = {i_din, shift_reg[LENGTH-1:1]};

  // Single-process FSM; a word landing in the output register overrides the drain-to-empty default.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      counter      <= '0;
      shift_reg    <= '0;
      ov_dout      <= '0;
      o_dout_valid <= 1'b0;
      o_busy       <= 1'b0;
    end else if (i_en) begin
      if (word_xfer) begin
        o_dout_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (bit_accept) begin
            shift_reg <= shift_next;
            counter   <= LENGTH_BITS'(1);
            state     <= SHIFT;
            o_busy    <= 1'b1;
          end
        end
        SHIFT: begin
          if (bit_accept) begin
            if (!last_bit) begin
              shift_reg <= shift_next;
              counter   <= counter + LENGTH_BITS'(1);
            end else if (!o_dout_valid || i_ready) begin
              ov_dout      <= shift_next;
              o_dout_valid <= 1'b1;
              shift_reg    <= '0;
              counter      <= '0;
              state        <= IDLE;
              o_busy       <= 1'b0;
            end else begin
              shift_reg <= shift_next;
              counter   <= counter + LENGTH_BITS'(1);
              state     <= FULL;
            end
          end
        end
        FULL: begin
          if (word_xfer) begin
            ov_dout      <= shift_reg;
            o_dout_valid <= 1'b1;
            shift_reg    <= '0;
            counter      <= '0;
            state        <= IDLE;
            o_busy       <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deserializer_fsm.sv
// Directed bench for deserializer_fsm: a vector table for one word plus hand-written
// sequences for back-to-back, backpressure, clock-enable, reset and collision cases.
module tb_deserializer_fsm;

  localparam int unsigned LENGTH = 24;

  logic              clk;
  logic              rst;
  logic              en;
  logic              din;
  logic              din_valid;
  logic              ready_in;
  logic              ready_out;
  logic [LENGTH-1:0] dout;
  logic              dout_valid;
  logic              busy;

  int total;
  int bad;

  logic [LENGTH-1:0] got[$];

  typedef struct {
    logic              en;
    logic              din;
    logic              din_valid;
    logic              ready;
    logic              exp_ready;
    logic              exp_valid;
    logic              exp_busy;
    logic [LENGTH-1:0] exp_dout;
  } vec_t;

  vec_t vecs[26];

  deserializer_fsm #(.LENGTH(LENGTH)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_din       (din),
    .i_din_valid (din_valid),
    .o_ready     (ready_out),
    .ov_dout     (dout),
    .o_dout_valid(dout_valid),
    .i_ready     (ready_in),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: capture every completed word transfer before the edge that performs it.
  always @(negedge clk) begin
    if (!rst && en && dout_valid && ready_in) got.push_back(dout);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic send_word(input logic [LENGTH-1:0] w, input logic rdy);
    for (int i = 0; i < int'(LENGTH); i++) begin
      din       = w[i];
      din_valid = 1'b1;
      ready_in  = rdy;
      tick();
    end
    din_valid = 1'b0;
  endtask

  task automatic check_sb(input string name, input int n, input logic [LENGTH-1:0] e0,
                          input logic [LENGTH-1:0] e1);
    check({name, "_count"}, 32'(got.size()), 32'(n));
    if (n >= 1 && got.size() >= 1) check({name, "_w0"}, 32'(got[0]), 32'(e0));
    if (n >= 2 && got.size() >= 2) check({name, "_w1"}, 32'(got[1]), 32'(e1));
  endtask

  initial begin
    logic [LENGTH-1:0] w;
    logic [LENGTH-1:0] w2;
    int                pulses[$];
    logic              ready_dropped;
    logic              valid_dropped;
    logic              snap_busy;
    logic              snap_valid;
    logic              snap_ready;
    logic [LENGTH-1:0] snap_dout;
    int                idx;
    int                cycles;
    logic              forced_off;

    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    en        = 1'b1;
    din       = 1'b0;
    din_valid = 1'b0;
    ready_in  = 1'b0;

    // Table: word 24'hA5C30F with continuous bits and a free consumer.
    w = 24'hA5C30F;
    for (int i = 0; i < 24; i++) begin
      vecs[i] = '{en: 1'b1, din: w[i], din_valid: 1'b1, ready: 1'b1, exp_ready: 1'b1,
                  exp_valid: (i == 23), exp_busy: (i < 23),
                  exp_dout: (i == 23) ? 24'hA5C30F : 24'h000000};
    end
    vecs[24] = '{en: 1'b1, din: 1'b0, din_valid: 1'b0, ready: 1'b1, exp_ready: 1'b1,
                 exp_valid: 1'b0, exp_busy: 1'b0, exp_dout: 24'hA5C30F};
    vecs[25] = '{en: 1'b0, din: 1'b1, din_valid: 1'b1, ready: 1'b1, exp_ready: 1'b1,
                 exp_valid: 1'b0, exp_busy: 1'b0, exp_dout: 24'hA5C30F};

    tick();
    tick();
    check("rst_ready", 32'(ready_out), 32'd0);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(ready_out), 32'd1);

    for (int i = 0; i < 26; i++) begin
      en        = vecs[i].en;
      din       = vecs[i].din;
      din_valid = vecs[i].din_valid;
      ready_in  = vecs[i].ready;
      tick();
      check($sformatf("vec%0d_ready", i), 32'(ready_out), 32'(vecs[i].exp_ready));
      check($sformatf("vec%0d_valid", i), 32'(dout_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d_dout", i), 32'(dout), 32'(vecs[i].exp_dout));
    end
    en        = 1'b1;
    din_valid = 1'b0;
    got.delete();

    // Back-to-back words, continuous bits, consumer always ready.
    w  = 24'h000001;
    w2 = 24'h800000;
    ready_dropped = 1'b0;
    ready_in      = 1'b1;
    for (int k = 0; k < 48; k++) begin
      din       = (k < 24) ? w[k] : w2[k-24];
      din_valid = 1'b1;
      if (!ready_out) ready_dropped = 1'b1;
      tick();
      if (dout_valid) pulses.push_back(k);
    end
    din_valid = 1'b0;
    tick();
    check("b2b_ready_never_dropped", 32'(ready_dropped), 32'd0);
    check("b2b_pulse_count", 32'(pulses.size()), 32'd2);
    if (pulses.size() == 2) begin
      check("b2b_pulse0_cycle", 32'(pulses[0]), 32'd23);
      check("b2b_pulse_spacing", 32'(pulses[1] - pulses[0]), 32'd24);
    end
    check("b2b_valid_after_drain", 32'(dout_valid), 32'd0);
    check_sb("b2b_sb", 2, 24'h000001, 24'h800000);
    got.delete();

    // Backpressure: two words stream in with the consumer stalled.
    send_word(24'h123456, 1'b0);
    check("bp_first_valid", 32'(dout_valid), 32'd1);
    check("bp_first_dout", 32'(dout), 32'h123456);
    check("bp_ready_mid", 32'(ready_out), 32'd1);
    send_word(24'hABCDEF, 1'b0);
    check("bp_full_ready", 32'(ready_out), 32'd0);
    check("bp_full_busy", 32'(busy), 32'd1);
    check("bp_full_dout_held", 32'(dout), 32'h123456);
    din       = 1'b1;
    din_valid = 1'b1;
    tick();
    tick();
    check("bp_stall_dout_held", 32'(dout), 32'h123456);
    check("bp_stall_ready", 32'(ready_out), 32'd0);
    din_valid = 1'b0;
    ready_in  = 1'b1;
    tick();
    ready_in  = 1'b0;
    check("bp_drain_valid", 32'(dout_valid), 32'd1);
    check("bp_drain_dout", 32'(dout), 32'hABCDEF);
    check("bp_drain_ready", 32'(ready_out), 32'd1);
    check("bp_drain_busy", 32'(busy), 32'd0);
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
    check("bp_final_valid", 32'(dout_valid), 32'd0);
    check_sb("bp_sb", 2, 24'h123456, 24'hABCDEF);
    got.delete();

    // Random valid gaps and enable drops while assembling one word.
    w          = 24'h5A5A5A;
    idx        = 0;
    cycles     = 0;
    forced_off = 1'b0;
    ready_in   = 1'b0;
    while (idx < 24 && cycles < 2000) begin
      din       = w[idx];
      din_valid = 1'($urandom_range(0, 1));
      en        = ($urandom_range(0, 3) != 0);
      if (idx == 12 && !forced_off) begin
        en         = 1'b0;
        din_valid  = 1'b1;
        forced_off = 1'b1;
      end
      snap_busy  = busy;
      snap_valid = dout_valid;
      snap_ready = ready_out;
      snap_dout  = dout;
      tick();
      cycles++;
      if (!en) begin
        check("en_off_busy", 32'(busy), 32'(snap_busy));
        check("en_off_valid", 32'(dout_valid), 32'(snap_valid));
        check("en_off_ready", 32'(ready_out), 32'(snap_ready));
        check("en_off_dout", 32'(dout), 32'(snap_dout));
      end else if (din_valid) begin
        idx++;
      end
    end
    check("rand_finished_in_budget", 32'(idx), 32'd24);
    en        = 1'b1;
    din_valid = 1'b0;
    #1;
    check("rand_valid", 32'(dout_valid), 32'd1);
    check("rand_dout", 32'(dout), 32'h5A5A5A);
    en       = 1'b0;
    ready_in = 1'b1;
    tick();
    check("rand_en_off_holds_valid", 32'(dout_valid), 32'd1);
    en = 1'b1;
    tick();
    ready_in = 1'b0;
    check("rand_drained", 32'(dout_valid), 32'd0);
    check_sb("rand_sb", 1, 24'h5A5A5A, 24'h000000);
    got.delete();

    // Asynchronous reset after 10 bits of a word.
    ready_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      din       = 1'b1;
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(dout_valid), 32'd0);
    check("arst_dout", 32'(dout), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ready", 32'(ready_out), 32'd0);
    tick();
    rst = 1'b0;
    send_word(24'h00FF00, 1'b0);
    check("arst_next_valid", 32'(dout_valid), 32'd1);
    check("arst_next_dout", 32'(dout), 32'h00FF00);
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
    check_sb("arst_sb", 1, 24'h00FF00, 24'h000000);
    got.delete();

    // Word completes in the same cycle the pending word transfers.
    send_word(24'h111111, 1'b0);
    w = 24'h222222;
    valid_dropped = 1'b0;
    for (int i = 0; i < 24; i++) begin
      din       = w[i];
      din_valid = 1'b1;
      ready_in  = (i == 23);
      tick();
      if (!dout_valid) valid_dropped = 1'b1;
    end
    din_valid = 1'b0;
    ready_in  = 1'b0;
    check("coll_valid_never_dropped", 32'(valid_dropped), 32'd0);
    check("coll_dout", 32'(dout), 32'h222222);
    check("coll_busy", 32'(busy), 32'd0);
    check("coll_ready", 32'(ready_out), 32'd1);
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
    check("coll_drained", 32'(dout_valid), 32'd0);
    check_sb("coll_sb", 2, 24'h111111, 24'h222222);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
